// File: rtl/midi_button_tx_if.sv
// Byte-stream handshake between the MIDI message builder and a serial transmitter.
`timescale 1ns/1ps
interface midi_button_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_button_tx.sv
// Turns debounced button level changes into 3-byte MIDI note on/off messages.
// Define MIDI_RUNNING_STATUS_EN to enable running status (releases become note-on, velocity 0).
`timescale 1ns/1ps
module midi_button_tx #(
  parameter int unsigned N_BTN     = 8,
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned BASE_NOTE = 60,
  parameter int unsigned VELOCITY  = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn,
  midi_button_tx_if.master   tx,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

  localparam logic [7:0] NOTE_ON  = 8'h90 | {4'h0, CHANNEL[3:0]};
  localparam logic [7:0] NOTE_OFF = 8'h80 | {4'h0, CHANNEL[3:0]};
  localparam logic [7:0] VEL_ON   = {1'b0, VELOCITY[6:0]};
`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic [7:0] STAT_REL = NOTE_ON;
  localparam logic [7:0] VEL_REL  = 8'h00;
`else
  localparam logic [7:0] STAT_REL = NOTE_OFF;
  localparam logic [7:0] VEL_REL  = 8'h40;
`endif

  state_t             state, state_next;
  logic [N_BTN-1:0]   sent_state;
  logic [3:0]         sel_idx;
  logic               sel_lvl;

  logic [N_BTN-1:0]   pend;
  logic [N_BTN-1:0]   pick_mask;
  logic [3:0]         pick_idx;
  logic               pick_lvl;
  logic               found;
  logic               skip_status;

  logic [7:0]         status_byte;
  logic [7:0]         note_byte;
  logic [7:0]         vel_byte;
  logic [7:0]         tx_data;
  logic               tx_valid;

  // Lowest-index pending button wins; level is sampled with the index so both are coherent.
  always_comb begin
    pend      = btn ^ sent_state;
    pick_mask = '0;
    pick_idx  = '0;
    pick_lvl  = 1'b0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (pend[i] && !found) begin
        found        = 1'b1;
        pick_idx     = 4'(i);
        pick_lvl     = btn[i];
        pick_mask[i] = 1'b1;
      end
    end
  end

  assign status_byte = sel_lvl ? NOTE_ON : STAT_REL;
  assign note_byte   = {1'b0, BASE_NOTE[6:0] + {3'b000, sel_idx}};
  assign vel_byte    = sel_lvl ? VEL_ON : VEL_REL;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       last_valid;

  always_comb begin
    skip_status = last_valid && (last_status == (pick_lvl ? NOTE_ON : STAT_REL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_status <= '0;
      last_valid  <= 1'b0;
    end else if (state == STATUS && tx.tx_ready) begin
      last_status <= status_byte;
      last_valid  <= 1'b1;
    end
  end
`else
  always_comb begin
    skip_status = 1'b0;
  end
`endif

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = '0;
    case (state)
      IDLE: begin
        if (found) state_next = skip_status ? NOTE : STATUS;
      end
      STATUS: begin
        tx_valid = 1'b1;
        tx_data  = status_byte;
        if (tx.tx_ready) state_next = NOTE;
      end
      NOTE: begin
        tx_valid = 1'b1;
        tx_data  = note_byte;
        if (tx.tx_ready) state_next = VEL;
      end
      VEL: begin
        tx_valid = 1'b1;
        tx_data  = vel_byte;
        if (tx.tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sent_state <= '0;
      sel_idx    <= '0;
      sel_lvl    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && found) begin
        sent_state <= sent_state ^ pick_mask;
        sel_idx    <= pick_idx;
        sel_lvl    <= pick_lvl;
      end
    end
  end

  assign tx.tx_valid = tx_valid;
  assign tx.tx_data  = tx_data;
  assign busy        = (state != IDLE);

endmodule
